// File: rtl/esp32_mem_arb_pkg.sv
// Shared types and constants for the ESP32 SPI / client memory arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package esp32_mem_arb_pkg;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 8;

    localparam logic [2:0] SPACE_MAIN = 3'd0;

    typedef enum logic {
        OWN_SPI = 1'b0,
        OWN_CLI = 1'b1
    } owner_t;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } spi_wr_t;

endpackage

// File: rtl/esp32_mem_arb_fifo.sv
// Generic synchronous show-ahead FIFO; DEPTH must be a power of 2.
// Latency: push visible at dout/empty one cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty.
module esp32_mem_arb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; pointers alone define occupancy.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/esp32_mem_arbiter.sv
// Arbitrates queued SPI writes, one held SPI read and a client port onto one req/ready memory port.
// Latency: SPI write strobe to mem_req 2 cycles; mem_rvalid to spi/cli read strobe 1 cycle.
// Backpressure: none toward SPI (drops set spi_ovf); client held until cli_ack; memory via mem_ready.
module esp32_mem_arbiter
    import esp32_mem_arb_pkg::*;
#(
    parameter int                 SPI_Q_DEPTH = 4,
    parameter int                 RD_TAGS     = 4,
    parameter int                 STARVE_MAX  = 8,
    parameter logic [DATA_W-1:0]  FILL_BYTE   = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_wr_en,
    input  logic [ADDR_W-1:0] spi_wr_addr,
    input  logic [DATA_W-1:0] spi_wr_data,
    input  logic              spi_rd_req,
    input  logic [2:0]        spi_rd_space,
    input  logic [ADDR_W-1:0] spi_rd_addr,
    output logic              spi_rd_valid,
    output logic [DATA_W-1:0] spi_rd_data,
    output logic              spi_ovf,
    input  logic              cli_req,
    input  logic              cli_we,
    input  logic [ADDR_W-1:0] cli_addr,
    input  logic [DATA_W-1:0] cli_wdata,
    output logic              cli_ack,
    output logic              cli_rvalid,
    output logic [DATA_W-1:0] cli_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);

    spi_wr_t           wq_din;
    spi_wr_t           wq_dout;
    logic              wq_push;
    logic              wq_pop;
    logic              wq_full;
    logic              wq_empty;

    logic              tag_push;
    logic              tag_pop;
    logic              tag_din;
    logic              tag_dout;
    logic              tag_full;
    logic              tag_empty;

    logic              rd_hold_vld;
    logic [ADDR_W-1:0] rd_hold_addr;
    logic              hold_clr;
    logic              rd_main;
    logic              fill_req;
    logic              fill_defer;

    state_t            st, st_nxt;
    owner_t            owner, owner_nxt;
    logic              req_nxt;
    logic              we_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic [SC_W-1:0]   starve_cnt, starve_nxt;

    logic              spi_pend;
    logic              spi_cand;
    logic              cli_cand;
    logic              spi_win;
    logic              grant_spi;
    logic              grant_cli;

    logic              ret_vld;
    logic              ret_spi;
    logic              ret_cli;

    assign wq_din   = {spi_wr_addr, spi_wr_data};
    assign wq_push  = spi_wr_en;
    assign rd_main  = spi_rd_req && (spi_rd_space == SPACE_MAIN);
    assign fill_req = spi_rd_req && (spi_rd_space != SPACE_MAIN);

    esp32_mem_arb_fifo #(
        .WIDTH ($bits(spi_wr_t)),
        .DEPTH (SPI_Q_DEPTH)
    ) u_wr_q (
        .clk   (clk),
        .rst   (rst),
        .push  (wq_push),
        .din   (wq_din),
        .pop   (wq_pop),
        .dout  (wq_dout),
        .full  (wq_full),
        .empty (wq_empty)
    );

    esp32_mem_arb_fifo #(
        .WIDTH (1),
        .DEPTH (RD_TAGS)
    ) u_tag_q (
        .clk   (clk),
        .rst   (rst),
        .push  (tag_push),
        .din   (tag_din),
        .pop   (tag_pop),
        .dout  (tag_dout),
        .full  (tag_full),
        .empty (tag_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_hold_vld  <= 1'b0;
            rd_hold_addr <= '0;
            spi_ovf      <= 1'b0;
        end else begin
            if ((spi_wr_en && wq_full) || (rd_main && rd_hold_vld)) spi_ovf <= 1'b1;
            if (hold_clr) begin
                rd_hold_vld <= 1'b0;
            end else if (rd_main && !rd_hold_vld) begin
                rd_hold_vld  <= 1'b1;
                rd_hold_addr <= spi_rd_addr;
            end
        end
    end

    // The held read waits behind every queued write so SPI sees its own writes.
    assign spi_pend = !wq_empty || rd_hold_vld;
    assign spi_cand = !wq_empty || (rd_hold_vld && !tag_full);
    assign cli_cand = cli_req && (cli_we || !tag_full);
    assign spi_win  = spi_cand && ((starve_cnt == SC_W'(STARVE_MAX)) || !cli_cand);
    assign cli_ack  = (st == ST_BUSY) && (owner == OWN_CLI) && mem_ready;
    assign tag_din  = (owner == OWN_CLI);

    always_comb begin
        st_nxt    = st;
        owner_nxt = owner;
        req_nxt   = mem_req;
        we_nxt    = mem_we;
        addr_nxt  = mem_addr;
        wdata_nxt = mem_wdata;
        wq_pop    = 1'b0;
        hold_clr  = 1'b0;
        tag_push  = 1'b0;
        grant_spi = 1'b0;
        grant_cli = 1'b0;
        case (st)
            ST_ARB: begin
                if (spi_win) begin
                    grant_spi = 1'b1;
                    owner_nxt = OWN_SPI;
                    req_nxt   = 1'b1;
                    st_nxt    = ST_BUSY;
                    if (!wq_empty) begin
                        we_nxt    = 1'b1;
                        addr_nxt  = wq_dout.addr;
                        wdata_nxt = wq_dout.data;
                    end else begin
                        we_nxt    = 1'b0;
                        addr_nxt  = rd_hold_addr;
                        wdata_nxt = '0;
                    end
                end else if (cli_cand) begin
                    grant_cli = 1'b1;
                    owner_nxt = OWN_CLI;
                    req_nxt   = 1'b1;
                    st_nxt    = ST_BUSY;
                    we_nxt    = cli_we;
                    addr_nxt  = cli_addr;
                    wdata_nxt = cli_we ? cli_wdata : '0;
                end
            end
            ST_BUSY: begin
                if (mem_ready) begin
                    req_nxt  = 1'b0;
                    st_nxt   = ST_ARB;
                    tag_push = !mem_we;
                    if (owner == OWN_SPI) begin
                        wq_pop   = mem_we;
                        hold_clr = !mem_we;
                    end
                end
            end
            default: st_nxt = ST_ARB;
        endcase

        starve_nxt = starve_cnt;
        if (!spi_pend || grant_spi) begin
            starve_nxt = '0;
        end else if (grant_cli && spi_cand && (starve_cnt != SC_W'(STARVE_MAX))) begin
            starve_nxt = starve_cnt + SC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= ST_ARB;
            owner      <= OWN_SPI;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            starve_cnt <= '0;
        end else begin
            st         <= st_nxt;
            owner      <= owner_nxt;
            mem_req    <= req_nxt;
            mem_we     <= we_nxt;
            mem_addr   <= addr_nxt;
            mem_wdata  <= wdata_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    assign ret_vld = mem_rvalid && !tag_empty;
    assign tag_pop = ret_vld;
    assign ret_spi = ret_vld && !tag_dout;
    assign ret_cli = ret_vld && tag_dout;

    // A memory return beats a same-cycle fill response; the fill slips one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spi_rd_valid <= 1'b0;
            spi_rd_data  <= '0;
            fill_defer   <= 1'b0;
            cli_rvalid   <= 1'b0;
            cli_rdata    <= '0;
        end else begin
            spi_rd_valid <= 1'b0;
            cli_rvalid   <= ret_cli;
            if (ret_cli) cli_rdata <= mem_rdata;
            if (ret_spi) begin
                spi_rd_valid <= 1'b1;
                spi_rd_data  <= mem_rdata;
                fill_defer   <= fill_defer || fill_req;
            end else if (fill_defer || fill_req) begin
                spi_rd_valid <= 1'b1;
                spi_rd_data  <= FILL_BYTE;
                fill_defer   <= fill_defer && fill_req;
            end
        end
    end

endmodule

// File: tb/tb_esp32_mem_arbiter.sv
// Scoreboard bench for esp32_mem_arbiter: stimulus queues expectations, negedge monitors check them.
module tb_esp32_mem_arbiter;
    import esp32_mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_wr_en = 1'b0;
    logic [23:0] spi_wr_addr = '0;
    logic [7:0]  spi_wr_data = '0;
    logic        spi_rd_req = 1'b0;
    logic [2:0]  spi_rd_space = '0;
    logic [23:0] spi_rd_addr = '0;
    logic        spi_rd_valid;
    logic [7:0]  spi_rd_data;
    logic        spi_ovf;
    logic        cli_req = 1'b0;
    logic        cli_we = 1'b0;
    logic [23:0] cli_addr = '0;
    logic [7:0]  cli_wdata = '0;
    logic        cli_ack;
    logic        cli_rvalid;
    logic [7:0]  cli_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [23:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ready = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [7:0]  mem_rdata = '0;

    esp32_mem_arbiter #(
        .SPI_Q_DEPTH (4),
        .RD_TAGS     (4),
        .STARVE_MAX  (8),
        .FILL_BYTE   (8'hFF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .spi_wr_en    (spi_wr_en),
        .spi_wr_addr  (spi_wr_addr),
        .spi_wr_data  (spi_wr_data),
        .spi_rd_req   (spi_rd_req),
        .spi_rd_space (spi_rd_space),
        .spi_rd_addr  (spi_rd_addr),
        .spi_rd_valid (spi_rd_valid),
        .spi_rd_data  (spi_rd_data),
        .spi_ovf      (spi_ovf),
        .cli_req      (cli_req),
        .cli_we       (cli_we),
        .cli_addr     (cli_addr),
        .cli_wdata    (cli_wdata),
        .cli_ack      (cli_ack),
        .cli_rvalid   (cli_rvalid),
        .cli_rdata    (cli_rdata),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [23:0] addr;
        logic [7:0]  wdata;
        int          at;
    } mexp_t;

    typedef struct {
        logic [7:0] d;
        int         at;
    } rexp_t;

    mexp_t mq[$];
    rexp_t sq[$];
    rexp_t cq[$];
    mexp_t me;
    rexp_t se;
    rexp_t ce;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ack_cnt = 0;
    int strobe_cnt = 0;
    int t0;
    int t1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic spi_wr(input logic [23:0] a, input logic [7:0] d);
        spi_wr_en = 1'b1; spi_wr_addr = a; spi_wr_data = d;
        tick(1);
        spi_wr_en = 1'b0;
    endtask

    task automatic spi_rd(input logic [2:0] sp, input logic [23:0] a);
        spi_rd_req = 1'b1; spi_rd_space = sp; spi_rd_addr = a;
        tick(1);
        spi_rd_req = 1'b0;
    endtask

    task automatic drain(input int budget, input string name);
        int k = 0;
        while ((mq.size() + sq.size() + cq.size()) != 0 && k < budget) begin
            tick(1);
            k++;
        end
        checks++;
        if ((mq.size() + sq.size() + cq.size()) != 0) begin
            failures++;
            $display("FAIL %s timeout pending=%0d required=0", name, mq.size() + sq.size() + cq.size());
        end
    endtask

    // Memory-port monitor: every accepted transfer must match the head of mq.
    always @(negedge clk) begin
        if (!rst && mem_req && mem_ready) begin
            if (mq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL mem_unexpected got we=%0b addr=%0h wdata=%0h required=none", mem_we, mem_addr, mem_wdata);
            end else begin
                me = mq.pop_front();
                chk("mem_xfer", {mem_we, mem_addr, mem_we ? mem_wdata : 8'h00},
                                {me.we, me.addr, me.we ? me.wdata : 8'h00});
                if (me.at >= 0) chk("mem_time", 64'(cyc), 64'(me.at));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && spi_rd_valid) begin
            if (sq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spi_unexpected got data=%0h required=none", spi_rd_data);
            end else begin
                se = sq.pop_front();
                chk("spi_rd_data", 64'(spi_rd_data), 64'(se.d));
                if (se.at >= 0) chk("spi_rd_time", 64'(cyc), 64'(se.at));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && cli_rvalid) begin
            if (cq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL cli_unexpected got data=%0h required=none", cli_rdata);
            end else begin
                ce = cq.pop_front();
                chk("cli_rdata", 64'(cli_rdata), 64'(ce.d));
                if (ce.at >= 0) chk("cli_rd_time", 64'(cyc), 64'(ce.at));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && cli_ack) ack_cnt++;
        if (spi_rd_valid || cli_rvalid) strobe_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        chk("reset_outputs",
            64'({mem_req, mem_we, mem_addr, mem_wdata, spi_rd_valid, spi_rd_data,
                 spi_ovf, cli_ack, cli_rvalid, cli_rdata}), 64'(0));
        chk("reset_starve", 64'(dut.starve_cnt), 64'(0));
        rst = 1'b0;
        tick(2);

        // SPI write burst, one transfer every 2 cycles
        mem_ready = 1'b1;
        t0 = cyc;
        mq.push_back('{1'b1, 24'h000100, 8'h11, t0 + 2});
        mq.push_back('{1'b1, 24'h000101, 8'h22, t0 + 4});
        mq.push_back('{1'b1, 24'h000102, 8'h33, t0 + 6});
        spi_wr(24'h000100, 8'h11);
        spi_wr(24'h000101, 8'h22);
        spi_wr(24'h000102, 8'h33);
        drain(30, "burst");

        // SPI memory read, return 3 cycles after the request
        t0 = cyc;
        mq.push_back('{1'b0, 24'h001234, 8'h00, t0 + 2});
        spi_rd(3'd0, 24'h001234);
        tick(2);
        mem_rvalid = 1'b1; mem_rdata = 8'h5A;
        sq.push_back('{8'h5A, cyc + 1});
        tick(1);
        mem_rvalid = 1'b0;
        drain(20, "spi_read");

        // Non-memory space answered with the fill byte, no memory access
        t0 = cyc;
        sq.push_back('{8'hFF, t0 + 1});
        spi_rd(3'd2, 24'h004444);
        chk("fill_no_memreq", 64'(mem_req), 64'(0));
        tick(2);
        chk("fill_no_memreq_late", 64'(mem_req), 64'(0));
        drain(10, "fill");

        // Same-cycle write and read: the write goes first
        t0 = cyc;
        mq.push_back('{1'b1, 24'h000010, 8'h11, t0 + 2});
        mq.push_back('{1'b0, 24'h000010, 8'h00, t0 + 4});
        spi_wr_en = 1'b1; spi_wr_addr = 24'h000010; spi_wr_data = 8'h11;
        spi_rd_req = 1'b1; spi_rd_space = 3'd0; spi_rd_addr = 24'h000010;
        tick(1);
        spi_wr_en = 1'b0; spi_rd_req = 1'b0;
        tick(4);
        mem_rvalid = 1'b1; mem_rdata = 8'h99;
        sq.push_back('{8'h99, cyc + 1});
        tick(1);
        mem_rvalid = 1'b0;
        drain(20, "raw");

        // Memory return colliding with a fill request
        mq.push_back('{1'b0, 24'h000042, 8'h00, -1});
        spi_rd(3'd0, 24'h000042);
        tick(3);
        t1 = cyc;
        mem_rvalid = 1'b1; mem_rdata = 8'h3C;
        spi_rd_req = 1'b1; spi_rd_space = 3'd5; spi_rd_addr = 24'h000001;
        sq.push_back('{8'h3C, t1 + 1});
        sq.push_back('{8'hFF, t1 + 2});
        tick(1);
        mem_rvalid = 1'b0; spi_rd_req = 1'b0;
        drain(20, "collision");

        // Client read routed back through the tag FIFO
        cli_req = 1'b1; cli_we = 1'b0; cli_addr = 24'h000555;
        mq.push_back('{1'b0, 24'h000555, 8'h00, -1});
        for (int k = 0; k < 20 && !cli_ack; k++) tick(1);
        chk("cli_ack_seen", 64'(cli_ack), 64'(1));
        cli_req = 1'b0;
        tick(1);
        mem_rvalid = 1'b1; mem_rdata = 8'hC3;
        cq.push_back('{8'hC3, cyc + 1});
        tick(1);
        mem_rvalid = 1'b0;
        drain(20, "cli_read");

        // Starvation guard: 1 client access before SPI is pending, then 8 more, then SPI
        ack_cnt = 0;
        mem_ready = 1'b0;
        cli_req = 1'b1; cli_we = 1'b1; cli_addr = 24'h00ABCD; cli_wdata = 8'h77;
        for (int i = 0; i < 9; i++) mq.push_back('{1'b1, 24'h00ABCD, 8'h77, -1});
        mq.push_back('{1'b1, 24'h000300, 8'h5E, -1});
        tick(1);
        spi_wr(24'h000300, 8'h5E);
        mem_ready = 1'b1;
        for (int k = 0; k < 100 && mq.size() != 0; k++) tick(1);
        cli_req = 1'b0;
        tick(2);
        chk("starve_client_acks", 64'(ack_cnt), 64'(9));
        chk("starve_cnt_cleared", 64'(dut.starve_cnt), 64'(0));
        drain(5, "starve");

        // Overflow: fifth write into a full queue is dropped
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) spi_wr(24'h000200 + 24'(i), 8'hA0 + 8'(i));
        tick(1);
        chk("ovf_set", 64'(spi_ovf), 64'(1));
        for (int i = 0; i < 4; i++) mq.push_back('{1'b1, 24'h000200 + 24'(i), 8'hA0 + 8'(i), -1});
        mem_ready = 1'b1;
        drain(40, "ovf_drain");
        tick(4);
        chk("ovf_sticky", 64'(spi_ovf), 64'(1));

        // Reset while BUSY with an SPI read still outstanding
        mq.push_back('{1'b0, 24'h000777, 8'h00, -1});
        spi_rd(3'd0, 24'h000777);
        drain(20, "pre_rst_read");
        mem_ready = 1'b0;
        cli_req = 1'b1; cli_we = 1'b0; cli_addr = 24'h000888;
        tick(2);
        chk("busy_before_rst", 64'(mem_req), 64'(1));
        strobe_cnt = 0;
        rst = 1'b1;
        cli_req = 1'b0;
        #1;
        chk("rst_mem_req", 64'(mem_req), 64'(0));
        chk("rst_ovf", 64'(spi_ovf), 64'(0));
        tick(1);
        rst = 1'b0;
        tick(1);
        mem_rvalid = 1'b1; mem_rdata = 8'hEE;
        tick(1);
        mem_rvalid = 1'b0;
        tick(3);
        chk("rst_no_strobe", 64'(strobe_cnt), 64'(0));
        chk("rst_mem_idle", 64'(mem_req), 64'(0));

        chk("mq_empty", 64'(mq.size()), 64'(0));
        chk("sq_empty", 64'(sq.size()), 64'(0));
        chk("cq_empty", 64'(cq.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
